// File: rtl/mat_result_drain_pkg.sv
// Shared types and defaults for the mat_mult result drain path.
package mat_result_drain_pkg;
  localparam int DEPTH_DEF      = 8;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int SUM_WIDTH_DEF  = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    CLEAR    = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mat_result_drain_if.sv
// Row-sum output stream: one row per valid/ready handshake.
interface mat_result_drain_if #(
  parameter int SUM_WIDTH = mat_result_drain_pkg::SUM_WIDTH_DEF,
  parameter int DEPTH     = mat_result_drain_pkg::DEPTH_DEF
) ();
  localparam int IDX_W = mat_result_drain_pkg::idx_width(DEPTH);

  logic [SUM_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_idx, output out_last, output out_valid,
                  input out_ready);
  modport slave  (input out_data, input out_idx, input out_last, input out_valid,
                  output out_ready);
endinterface

// File: rtl/mat_result_drain.sv
// Captures all mat_mult row sums on a done rising edge, streams them out row 0 first,
// then pulses clr_o and waits for done to drop before arming again.
module mat_result_drain
  import mat_result_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int SUM_WIDTH  = 3 * DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             done_i,
  input  logic [DEPTH-1:0][SUM_WIDTH-1:0]  sum_i,
  mat_result_drain_if.master               out_bus,
  output logic                             clr_o,
  output logic                             busy,
  output logic                             overrun,
  input  logic                             err_clr
);
  localparam int IDX_W = idx_width(DEPTH);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [SUM_WIDTH-1:0] shadow_q [DEPTH];
  logic                 done_q;
  logic                 primed_q;
  logic                 rise, at_last, fire;
  logic                 valid_c, last_c, clr_c, busy_c;
  logic [SUM_WIDTH-1:0] data_c;

  // primed_q masks the first cycle after reset so a done level already high is not a rise
  assign rise    = done_i & ~done_q & primed_q;
  assign at_last = (idx_q == IDX_W'(DEPTH - 1));
  assign fire    = valid_c & out_bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rise) state_d = SEND;
      SEND:     if (fire && at_last) state_d = CLEAR;
      CLEAR:    state_d = WAIT_LOW;
      WAIT_LOW: if (!done_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_c = (state_q == SEND);
    last_c  = (state_q == SEND) && at_last;
    clr_c   = (state_q == CLEAR);
    busy_c  = (state_q != IDLE);
    data_c  = valid_c ? shadow_q[idx_q] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      done_q   <= 1'b0;
      primed_q <= 1'b0;
      overrun  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
    end else begin
      done_q   <= done_i;
      primed_q <= 1'b1;
      if (state_q == IDLE && rise) begin
        idx_q <= '0;
        for (int i = 0; i < DEPTH; i++) shadow_q[i] <= sum_i[i];
      end else if (fire && !at_last) begin
        idx_q <= idx_q + 1'b1;
      end
      // a new overrun event takes priority over a simultaneous clear
      if (rise && state_q != IDLE) overrun <= 1'b1;
      else if (err_clr)            overrun <= 1'b0;
    end
  end

  assign out_bus.out_valid = valid_c;
  assign out_bus.out_last  = last_c;
  assign out_bus.out_data  = data_c;
  assign out_bus.out_idx   = idx_q;
  assign clr_o             = clr_c;
  assign busy              = busy_c;
endmodule

// File: tb/tb_mat_result_drain.sv
// Scoreboard bench for mat_result_drain: random frames, stalls, overrun and mid-frame reset.
module tb_mat_result_drain;
  localparam int DEPTH = 8;
  localparam int SW    = 24;

  typedef logic [DEPTH-1:0][SW-1:0] frame_t;
  typedef struct {
    logic [SW-1:0] data;
    int            idx;
    bit            last;
  } row_t;

  logic   clk = 1'b0;
  logic   rst;
  logic   done_i;
  frame_t sum_i;
  logic   clr_o, busy, overrun, err_clr;

  mat_result_drain_if #(.SUM_WIDTH(SW), .DEPTH(DEPTH)) bus ();

  mat_result_drain #(.DATA_WIDTH(8), .DEPTH(DEPTH), .SUM_WIDTH(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .done_i  (done_i),
    .sum_i   (sum_i),
    .out_bus (bus),
    .clr_o   (clr_o),
    .busy    (busy),
    .overrun (overrun),
    .err_clr (err_clr)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  bit   ov_exp = 0;
  row_t exp_q[$];

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer ready: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
  initial begin
    int k;
    k = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: bus.out_ready = 1'b1;
      endcase
      k++;
    end
  end

  // Monitor: every presented row must equal the head of the expected queue
  initial begin
    bit   clr_exp;
    row_t e;
    clr_exp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        clr_exp = 0;
      end else begin
        chk("clr_o_timing", clr_o, clr_exp);
        clr_exp = 0;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", bus.out_valid, 0);
          end else begin
            e = exp_q[0];
            chk("out_data", bus.out_data, e.data);
            chk("out_idx",  bus.out_idx,  e.idx);
            chk("out_last", bus.out_last, e.last);
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              if (e.last) clr_exp = 1;
            end
          end
        end else if (bus.out_last) begin
          chk("last_without_valid", bus.out_last, 0);
        end
      end
    end
  end

  function automatic frame_t rand_frame();
    frame_t f;
    for (int r = 0; r < DEPTH; r++) f[r] = SW'($urandom);
    return f;
  endfunction

  task automatic push_frame(input frame_t sums);
    row_t e;
    for (int r = 0; r < DEPTH; r++) begin
      e.data = sums[r];
      e.idx  = r;
      e.last = (r == DEPTH - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_frame(input frame_t sums, input int mode, input bit pulse_ov, input int hold);
    int t0, guard;
    frame_t junk;
    ready_mode = mode;
    sum_i = sums;
    @(posedge clk); #1;
    done_i = 1'b1;
    t0 = cyc;
    push_frame(sums);
    @(negedge clk);
    chk("pre_capture_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    for (int r = 0; r < DEPTH; r++) junk[r] = '1;
    sum_i = junk;
    if (pulse_ov) done_i = 1'b0;
    @(negedge clk);
    chk("latency_valid", bus.out_valid, 1);
    chk("busy_in_send", busy, 1);
    if (pulse_ov) begin
      @(posedge clk); #1;
      done_i = 1'b1;
      ov_exp = 1;
    end
    for (guard = 0; guard < 400; guard++) begin
      @(negedge clk);
      if (clr_o) break;
    end
    if (guard >= 400) chk("frame_timeout", 1, 0);
    else if (mode == 0) chk("frame_cycles", 64'(cyc - t0), DEPTH + 1);
    chk("overrun_after_frame", overrun, ov_exp);
    repeat (hold) begin
      @(negedge clk);
      chk("wait_low_busy", busy, 1);
      chk("wait_low_valid", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    done_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("rows_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    frame_t f;
    rst = 1'b1;
    done_i = 1'b1;
    err_clr = 1'b0;
    sum_i = '0;
    #2;
    chk("rst_valid",   bus.out_valid, 0);
    chk("rst_last",    bus.out_last,  0);
    chk("rst_clr",     clr_o,         0);
    chk("rst_busy",    busy,          0);
    chk("rst_overrun", overrun,       0);
    chk("rst_idx",     bus.out_idx,   0);
    chk("rst_data",    bus.out_data,  0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    // done_i high straight out of reset must not start a frame
    repeat (4) @(negedge clk);
    chk("no_frame_from_reset_level", busy, 0);
    @(posedge clk); #1;
    done_i = 1'b0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < DEPTH; r++) f[r] = SW'(r + 1);
    run_frame(f, 0, 0, 0);
    run_frame(rand_frame(), 2, 0, 0);
    run_frame(rand_frame(), 1, 0, 0);
    run_frame(rand_frame(), 0, 0, 6);

    run_frame(rand_frame(), 0, 1, 2);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    ov_exp = 0;
    @(negedge clk);
    chk("overrun_cleared", overrun, 0);

    // Reset while row 3 is on the bus abandons the frame
    ready_mode = 0;
    f = rand_frame();
    sum_i = f;
    @(posedge clk); #1;
    done_i = 1'b1;
    push_frame(f);
    repeat (5) @(negedge clk);
    chk("row3_before_reset", bus.out_idx, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_idx",   bus.out_idx,   0);
    chk("midrst_data",  bus.out_data,  0);
    chk("midrst_busy",  busy,          0);
    chk("midrst_clr",   clr_o,         0);
    done_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("no_clr_after_reset", clr_o, 0);
    end
    run_frame(rand_frame(), 0, 0, 0);

    for (int n = 0; n < 6; n++) run_frame(rand_frame(), 1, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    chk("final_overrun", overrun, ov_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
